// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 values, memory size
// codes, the controller state type and the access-size helper.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] MEM_SZ_B = 3'b000;
   localparam logic [2:0] MEM_SZ_H = 3'b001;
   localparam logic [2:0] MEM_SZ_W = 3'b010;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } lsu_state_e;

   // Access size in bytes; 0 marks an encoding with no legal size.
   function automatic logic [2:0] size_of(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         2'b10:   return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// RV32I load-result extension: sign/zero-extends byte and halfword loads,
// passes words through untouched.
module load_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   always_comb begin
      ext = raw;
      case (funct3)
         F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
         F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
         F3_BU:   ext = {24'h0, raw[7:0]};
         F3_HU:   ext = {16'h0, raw[15:0]};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator for RV32I loads/stores: checks legality and range,
// splits misaligned accesses into byte beats and returns one registered response.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = 4096,
   parameter bit SPLIT_EN  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_read,
   output logic        mem_write,
   output logic [2:0]  mem_funct3,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   lsu_state_e  state_q, state_d;
   logic [31:0] base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] asm_q, asm_d;
   logic [2:0]  f3_q, f3_d;
   logic        write_q, write_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  last_q, last_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_fault_q, resp_fault_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   logic [2:0]  size;
   logic [32:0] end_addr;
   logic        legal, aligned, in_range, fault, accept;
   logic [31:0] asm_next, ext_raw, ext_data;
   logic [2:0]  ext_f3;

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_fault = resp_fault_q;

   always_comb begin
      size     = size_of(req_funct3);
      legal    = req_write ? (req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W)
                           : (req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W ||
                              req_funct3 == F3_BU || req_funct3 == F3_HU);
      aligned  = (size == 3'd1) ||
                 (size == 3'd2 && !req_addr[0]) ||
                 (size == 3'd4 && req_addr[1:0] == 2'b00);
      // 33-bit end address so a wrap past 0xFFFFFFFF still lands out of range
      end_addr = {1'b0, req_addr} + {30'h0, size} - 33'd1;
      in_range = end_addr < 33'(MEM_BYTES);
      fault    = !legal || !in_range || (!aligned && !SPLIT_EN);
      accept   = req_valid && req_ready && !rst;
   end

   // Assembly register with the current beat's byte merged in, so the final
   // beat can be extended and registered in the same cycle it is read.
   always_comb begin
      asm_next = asm_q;
      asm_next[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
      ext_f3  = (state_q == SPLIT) ? f3_q : req_funct3;
      ext_raw = (state_q == SPLIT) ? asm_next : mem_rdata;
   end

   load_extend u_load_extend (
      .funct3 (ext_f3),
      .raw    (ext_raw),
      .ext    (ext_data)
   );

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      wdata_d      = wdata_q;
      asm_d        = asm_q;
      f3_d         = f3_q;
      write_d      = write_q;
      cnt_d        = cnt_q;
      last_d       = last_q;
      resp_valid_d = 1'b0;
      resp_fault_d = resp_fault_q;
      resp_rdata_d = resp_rdata_q;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_funct3   = 3'b000;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (fault) begin
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
                  resp_rdata_d = 32'h0;
               end else if (aligned) begin
                  mem_read     = !req_write;
                  mem_write    = req_write;
                  mem_funct3   = {1'b0, req_funct3[1:0]};
                  mem_addr     = req_addr;
                  mem_wdata    = req_wdata;
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b0;
                  resp_rdata_d = req_write ? 32'h0 : ext_data;
               end else begin
                  mem_read   = !req_write;
                  mem_write  = req_write;
                  mem_funct3 = MEM_SZ_B;
                  mem_addr   = req_addr;
                  mem_wdata  = {24'h0, req_wdata[7:0]};
                  base_d     = req_addr;
                  wdata_d    = req_wdata;
                  f3_d       = req_funct3;
                  write_d    = req_write;
                  asm_d      = {24'h0, mem_rdata[7:0]};
                  cnt_d      = 2'd1;
                  last_d     = 2'(size - 3'd1);
                  state_d    = SPLIT;
               end
            end
         end
         SPLIT: begin
            // Reset aborts the split before the beat reaches memory.
            if (!rst) begin
               mem_read   = !write_q;
               mem_write  = write_q;
               mem_funct3 = MEM_SZ_B;
               mem_addr   = base_q + {30'h0, cnt_q};
               mem_wdata  = {24'h0, wdata_q[{cnt_q, 3'b000} +: 8]};
               asm_d      = asm_next;
               if (cnt_q == last_q) begin
                  state_d      = IDLE;
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b0;
                  resp_rdata_d = write_q ? 32'h0 : ext_data;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         cnt_q        <= 2'd0;
         last_q       <= 2'd0;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
         resp_valid_q <= resp_valid_d;
         resp_fault_q <= resp_fault_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      base_q  <= base_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      f3_q    <= f3_d;
   end

endmodule
